pwr_logic_pipe: RTL and testbench

Parametrised, pipelined, multi-lane successor to the 4-input power-experiment logic cell. Each lane evaluates `y = (a & d) | (~(a ^ b) & (b ^ c))` on one bit of four WIDTH-bit operand vectors. A per-beat mode selects normal, inverted or single-term evaluation. Results pass through PIPE register stages under a valid/ready handshake. An on-block output-toggle counter gives a switching-activity figure for power-rewrite experiments.

---
 rtl/pwr_logic_pipe_if.sv | 26 ++
 rtl/pwr_logic_pipe.sv | 99 +++++++++
 tb/tb_pwr_logic_pipe.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwr_logic_pipe_if.sv
// Handshake and operand/result bundle for pwr_logic_pipe.
// A beat transfers on a rising edge where valid & ready are both 1; the sender holds valid/data until then.
interface pwr_logic_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;

  modport master (
    output in_valid, a, b, c, d, mode, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, c, d, mode, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/pwr_logic_pipe.sv
// Pipelined multi-lane power-experiment logic cell with saturating output-toggle and beat counters.
// All stages advance together; a stalled output freezes the whole pipe.
module pwr_logic_pipe #(
  parameter int WIDTH = 8,
  parameter int PIPE  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pwr_logic_pipe_if.slave  bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] beat_cnt
);
  localparam int SUM_W = ((CNT_W > 32) ? CNT_W : 32) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] t_and, t_xnor, f_full, lane_res;
  logic             adv, out_hs;
  logic [PIPE-1:0]  vld_q, vld_d;
  logic [WIDTH-1:0] res_q [PIPE];
  logic [WIDTH-1:0] res_d [PIPE];
  logic [WIDTH-1:0] last_y_q, last_y_d;
  logic [CNT_W-1:0] tog_q, tog_d, beat_q, beat_d;
  logic [SUM_W-1:0] pop, tog_base, beat_base, tog_sum, beat_sum;

  always_comb begin
    t_and  = bus.a & bus.d;
    t_xnor = ~(bus.a ^ bus.b) & (bus.b ^ bus.c);
    f_full = t_and | t_xnor;
    case (bus.mode)
      2'b00:   lane_res = f_full;
      2'b01:   lane_res = ~f_full;
      2'b10:   lane_res = t_xnor;
      default: lane_res = t_and;
    endcase
  end

  assign adv           = ~vld_q[PIPE-1] | bus.out_ready;
  assign out_hs        = vld_q[PIPE-1] & bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[PIPE-1];
  assign bus.y         = res_q[PIPE-1];
  assign toggle_cnt    = tog_q;
  assign beat_cnt      = beat_q;

  // Result registers only load behind a valid bit, so bubbles leave data lines quiet.
  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    if (adv) begin
      vld_d[0] = bus.in_valid;
      if (bus.in_valid) res_d[0] = lane_res;
      for (int i = 1; i < PIPE; i++) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) res_d[i] = res_q[i-1];
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + SUM_W'(res_q[PIPE-1][i] ^ last_y_q[i]);
    end
    tog_base  = cnt_clr ? '0 : SUM_W'(tog_q);
    beat_base = cnt_clr ? '0 : SUM_W'(beat_q);
    tog_sum   = tog_base + pop;
    beat_sum  = beat_base + SUM_W'(1);
    tog_d     = tog_q;
    beat_d    = beat_q;
    last_y_d  = last_y_q;
    // A clear in the same cycle as a handshake restarts the counts from this beat.
    if (out_hs) begin
      tog_d    = (tog_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : tog_sum[CNT_W-1:0];
      beat_d   = (beat_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : beat_sum[CNT_W-1:0];
      last_y_d = res_q[PIPE-1];
    end else if (cnt_clr) begin
      tog_d  = '0;
      beat_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      last_y_q <= '0;
      tog_q    <= '0;
      beat_q   <= '0;
      for (int i = 0; i < PIPE; i++) res_q[i] <= '0;
    end else begin
      vld_q    <= vld_d;
      last_y_q <= last_y_d;
      tog_q    <= tog_d;
      beat_q   <= beat_d;
      for (int i = 0; i < PIPE; i++) res_q[i] <= res_d[i];
    end
  end
endmodule

// File: tb/tb_pwr_logic_pipe.sv
// Bench for pwr_logic_pipe (WIDTH=4, PIPE=2, CNT_W=4): vector table, corner sequences and random traffic
// checked against a lane-by-lane reference model with a result queue and counter model.
module tb_pwr_logic_pipe;
  localparam int W    = 4;
  localparam int P    = 2;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct {
    logic [W-1:0] a, b, c, d;
    logic [1:0]   mode;
    logic [W-1:0] y;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] toggle_cnt, beat_cnt;
  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;
  logic [W-1:0]  exp_q[$];
  int            m_tog = 0;
  int            m_beat = 0;
  logic [W-1:0]  m_last = '0;
  logic [W-1:0]  mon_e;
  int            mon_base;
  vec_t          vecs[6];
  logic [W-1:0]  y_hold;

  pwr_logic_pipe_if #(.WIDTH(W)) bus ();

  pwr_logic_pipe #(.WIDTH(W), .PIPE(P), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cnt_clr    (cnt_clr),
    .toggle_cnt (toggle_cnt),
    .beat_cnt   (beat_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_y(input logic [W-1:0] a, b, c, d, input logic [1:0] mode);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      bit pa, px;
      pa = a[i] && d[i];
      px = (a[i] == b[i]) && (b[i] != c[i]);
      case (mode)
        2'd0:    r[i] = pa || px;
        2'd1:    r[i] = !(pa || px);
        2'd2:    r[i] = px;
        default: r[i] = pa;
      endcase
    end
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: counters compared first, then this cycle's handshakes update the model.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("toggle_cnt", 32'(toggle_cnt), 32'(m_tog));
      chk("beat_cnt", 32'(beat_cnt), 32'(m_beat));
      chk("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra_beat: got y=%0h expected no beat", bus.y);
          mon_e = bus.y;
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_y", 32'(bus.y), 32'(mon_e));
        end
        mon_base = cnt_clr ? 0 : m_tog;
        m_tog    = sat(mon_base + $countones(mon_e ^ m_last));
        mon_base = cnt_clr ? 0 : m_beat;
        m_beat   = sat(mon_base + 1);
        m_last   = mon_e;
      end else if (cnt_clr) begin
        m_tog  = 0;
        m_beat = 0;
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(ref_y(bus.a, bus.b, bus.c, bus.d, bus.mode));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [W-1:0] a, b, c, d, input logic [1:0] m);
    bus.a = a; bus.b = b; bus.c = c; bus.d = d; bus.mode = m;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic rand_data();
    bus.a = W'($urandom); bus.b = W'($urandom);
    bus.c = W'($urandom); bus.d = W'($urandom);
    bus.mode = 2'($urandom_range(3));
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    cnt_clr = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_y", 32'(bus.y), 32'd0);
    chk("rst_toggle", 32'(toggle_cnt), 32'd0);
    chk("rst_beat", 32'(beat_cnt), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    m_tog = 0; m_beat = 0; m_last = '0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n, input int pv, input int pr, input bit use_clr);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(99) < pv);
        rand_data();
      end
      bus.out_ready = ($urandom_range(99) < pr);
      cnt_clr = use_clr && ($urandom_range(9) == 0);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    cnt_clr = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    vecs[0] = '{4'b1010, 4'b1100, 4'b0110, 4'b0001, 2'b00, 4'b1000};
    vecs[1] = '{4'b1010, 4'b1100, 4'b0110, 4'b0001, 2'b01, 4'b0111};
    vecs[2] = '{4'b1010, 4'b1100, 4'b0110, 4'b0001, 2'b11, 4'b0000};
    vecs[3] = '{4'b1010, 4'b1100, 4'b0110, 4'b0001, 2'b10, 4'b1000};
    vecs[4] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000, 2'b00, 4'b1111};
    vecs[5] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111, 2'b11, 4'b1111};

    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0; bus.mode = '0;
    #1;
    chk("init_out_valid", 32'(bus.out_valid), 32'd0);
    chk("init_y", 32'(bus.y), 32'd0);
    chk("init_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Table: each result must be absent one cycle after acceptance and present the next.
    foreach (vecs[i]) begin
      send_beat(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].mode);
      @(negedge clk);
      chk($sformatf("vec%0d_early", i), 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_y", i), 32'(bus.y), 32'(vecs[i].y));
      @(posedge clk);
      #1;
    end

    // Toggle count 0000 -> 1111 -> 0000 from a fresh last_y.
    do_reset();
    send_beat('0, '0, '0, '0, 2'b00);
    send_beat('1, '1, '0, '0, 2'b00);
    send_beat('0, '0, '0, '0, 2'b00);
    tick(3);
    chk("toggle_seq_tog", 32'(toggle_cnt), 32'd8);
    chk("toggle_seq_beat", 32'(beat_cnt), 32'd3);

    // Saturation: 16 toggles must stick at 15.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) send_beat('1, '1, '0, '0, 2'b00);
      else send_beat('0, '0, '0, '0, 2'b00);
    end
    tick(3);
    chk("sat_tog", 32'(toggle_cnt), 32'd15);
    chk("sat_beat", 32'(beat_cnt), 32'd4);

    // Clear coinciding with the handshake of y=1111 after two zero beats.
    do_reset();
    send_beat('0, '0, '0, '0, 2'b00);
    send_beat('0, '0, '0, '0, 2'b00);
    tick(3);
    chk("pre_clr_beat", 32'(beat_cnt), 32'd2);
    send_beat('1, '1, '0, '0, 2'b00);
    tick(1);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_hs_tog", 32'(toggle_cnt), 32'd4);
    chk("clr_hs_beat", 32'(beat_cnt), 32'd1);
    @(posedge clk);
    #1;

    // Backpressure: fill, stall 5 cycles with in_valid held, release and drain.
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      tick(1);
    end
    rand_data();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) y_hold = bus.y;
      else chk("stall_y_stable", 32'(bus.y), 32'(y_hold));
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      rand_data();
    end
    bus.in_valid = 1'b0;
    tick(4);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two beats in flight: nothing stale may emerge.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    rand_data();
    tick(1);
    rand_data();
    tick(1);
    bus.in_valid = 1'b0;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Random traffic with occasional clears.
    stream(200, 80, 100, 1'b0);
    stream(400, 60, 60, 1'b1);
    stream(200, 100, 30, 1'b1);
    tick(6);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
